// File: rtl/count_enable_gen.sv
// rtl/count_enable_gen.sv - debounced start/stop button driving a prescaled count enable
// Optional AUTO_STOP_EN: counter overflow (ovf_in) forces STOPPED while RUNNING.
module count_enable_gen #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TICK_DIV        = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   input  logic ovf_in,
   output logic enable,
   output logic running,
   output logic btn_pulse
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

   typedef enum logic {ST_STOPPED = 1'b0, ST_RUNNING = 1'b1} state_t;

   logic            sync1_q, sync2_q;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            stable_q, stable_d;
   logic            pulse_q, pulse_d;
   state_t          state_q, state_d;
   logic [PS_W-1:0] presc_q, presc_d;
   logic            ovf_stop;

`ifdef AUTO_STOP_EN
   assign ovf_stop = ovf_in;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_in;
   assign ovf_stop   = 1'b0;
`endif

   // A level change is accepted only after it has persisted DEBOUNCE_CYCLES edges.
   always_comb begin
      db_cnt_d = db_cnt_q;
      stable_d = stable_q;
      pulse_d  = 1'b0;
      if (sync2_q == stable_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q != DB_LAST) begin
         db_cnt_d = db_cnt_q + DB_W'(1);
      end else begin
         stable_d = sync2_q;
         db_cnt_d = '0;
         pulse_d  = sync2_q;
      end
   end

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      case (state_q)
         ST_STOPPED: begin
            presc_d = '0;
            if (pulse_q) state_d = ST_RUNNING;
         end
         ST_RUNNING: begin
            if (ovf_stop || pulse_q) begin
               state_d = ST_STOPPED;
               presc_d = '0;
            end else begin
               presc_d = (presc_q == PS_LAST) ? '0 : presc_q + PS_W'(1);
            end
         end
         default: begin
            state_d = ST_STOPPED;
            presc_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         db_cnt_q <= '0;
         stable_q <= 1'b0;
         pulse_q  <= 1'b0;
         state_q  <= ST_STOPPED;
         presc_q  <= '0;
      end else begin
         sync1_q  <= btn_in;
         sync2_q  <= sync1_q;
         db_cnt_q <= db_cnt_d;
         stable_q <= stable_d;
         pulse_q  <= pulse_d;
         state_q  <= state_d;
         presc_q  <= presc_d;
      end
   end

   assign running   = (state_q == ST_RUNNING);
   assign enable    = (state_q == ST_RUNNING) && (presc_q == PS_LAST);
   assign btn_pulse = pulse_q;

endmodule

// File: tb/tb_count_enable_gen.sv
// tb/tb_count_enable_gen.sv - directed and randomized checks of count_enable_gen against a behavioural model
module tb_count_enable_gen;

   localparam int D   = 4;
   localparam int DIV = 10;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic btn_in = 1'b0;
   logic ovf_in = 1'b0;
   logic enable, running, btn_pulse;

   int total = 0;
   int bad   = 0;

   count_enable_gen #(.DEBOUNCE_CYCLES(D), .TICK_DIV(DIV)) dut (
      .clk(clk), .reset(reset), .btn_in(btn_in), .ovf_in(ovf_in),
      .enable(enable), .running(running), .btn_pulse(btn_pulse)
   );

   always #5 clk = ~clk;

   // Model: btn_sync is the input seen two edges earlier; a new level is accepted once
   // the last D synced samples all disagree with the accepted level.
   logic p0_m, p1_m, stable_m, pulse_m, run_m;
   int   t_m;
   logic hist[$];

   task automatic chk(input string tag, input logic got, input logic exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0b expected %0b at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input logic r, input logic b, input logic o);
      logic sync_now, acc, nrun;
      int   nt;
      if (r) begin
         p0_m = 0; p1_m = 0; hist.delete();
         stable_m = 0; pulse_m = 0; run_m = 0; t_m = 0;
      end else begin
         sync_now = p1_m;
         p1_m = p0_m;
         p0_m = b;
         hist.push_back(sync_now);
         if (hist.size() > 16) void'(hist.pop_front());
         acc = (hist.size() >= D);
         for (int i = 0; i < D; i++)
            if (hist.size() >= D && hist[hist.size()-1-i] == stable_m) acc = 0;
         nrun = run_m;
         nt   = t_m + 1;
`ifdef AUTO_STOP_EN
         if (run_m && o) begin nrun = 0; nt = 0; end
         else
`endif
         if (pulse_m) begin nrun = !run_m; nt = 0; end
         if (acc) stable_m = !stable_m;
         pulse_m = acc && stable_m;
         run_m = nrun;
         t_m = nt;
      end
   endtask

   task automatic step(input logic r, input logic b, input logic o);
      @(negedge clk);
      reset = r; btn_in = b; ovf_in = o;
      @(posedge clk);
      model_edge(r, b, o);
      #1;
      chk("running", running, run_m);
      chk("btn_pulse", btn_pulse, pulse_m);
      chk("enable", enable, run_m && (t_m % DIV == DIV - 1));
   endtask

   initial begin
      // reset for 2 cycles
      for (int k = 0; k < 2; k++) begin
         step(1, 0, 0);
         chk("rst_enable", enable, 1'b0);
         chk("rst_running", running, 1'b0);
         chk("rst_pulse", btn_pulse, 1'b0);
      end
      for (int k = 0; k < 3; k++) step(0, 0, 0);

      // held press: pulse at E5, running from E6, ticks at E15, E25
      for (int k = 0; k < 27; k++) begin
         step(0, 1, 0);
         chk("press_pulse", btn_pulse, k == 5);
         chk("press_running", running, k >= 6);
         chk("press_enable", enable, k == 15 || k == 25);
      end

      // release, then press landing its pulse on the tick cycle
      for (int k = 0; k < 10; k++) step(0, 0, 0);
      for (int k = 0; k < 20 && !(run_m && t_m % DIV == 3); k++) step(0, 0, 0);
      chk("align_ok", run_m && (t_m % DIV == 3), 1'b1);
      for (int k = 0; k < 6; k++) step(0, 1, 0);
      chk("coinc_enable", enable, 1'b1);
      chk("coinc_pulse", btn_pulse, 1'b1);
      step(0, 1, 0);
      chk("coinc_stopped", running, 1'b0);
      for (int k = 0; k < 12; k++) begin
         step(0, 1, 0);
         chk("after_stop_enable", enable, 1'b0);
      end

      // short press of 3 cycles is rejected
      for (int k = 0; k < 8; k++) step(0, 0, 0);
      for (int k = 0; k < 3; k++) step(0, 1, 0);
      for (int k = 0; k < 10; k++) begin
         step(0, 0, 0);
         chk("short_pulse", btn_pulse, 1'b0);
         chk("short_running", running, 1'b0);
      end

      // start, then reset mid-run
      for (int k = 0; k < 20; k++) step(0, 1, 0);
      for (int k = 0; k < 8; k++) step(0, 0, 0);
      chk("pre_reset_running", running, 1'b1);
      step(1, 0, 0);
      chk("mid_reset_running", running, 1'b0);
      chk("mid_reset_enable", enable, 1'b0);
      for (int k = 0; k < 25; k++) begin
         step(0, 0, 0);
         chk("post_reset_enable", enable, 1'b0);
      end

      // start, then a lone overflow pulse
      for (int k = 0; k < 12; k++) step(0, 1, 0);
      for (int k = 0; k < 8; k++) step(0, 0, 0);
      step(0, 0, 1);
`ifdef AUTO_STOP_EN
      chk("ovf_running", running, 1'b0);
`else
      chk("ovf_running", running, 1'b1);
`endif
      for (int k = 0; k < 12; k++) step(0, 0, 0);

      // randomized button activity with sporadic overflow and reset
      for (int seg = 0; seg < 300; seg++) begin
         logic lvl;
         int   len;
         lvl = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 12);
         for (int k = 0; k < len; k++)
            step($urandom_range(0, 199) == 0, lvl, $urandom_range(0, 19) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
